boa_peri_gpio_imatrix: RTL and testbench



---
 rtl/boa_peri_gpio_imatrix_if.sv | 11 +
 rtl/boa_peri_gpio_imatrix.sv | 118 +++++++++++
 tb/tb_boa_peri_gpio_imatrix.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boa_peri_gpio_imatrix_if.sv
// rtl/boa_peri_gpio_imatrix_if.sv - boa_mem_bus peripheral bus interface
interface boa_mem_bus;
  logic [29:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input addr, input we, input wdata, output rdata, output ready);
  modport CPU (output addr, output we, output wdata, input rdata, input ready);
endinterface

// File: rtl/boa_peri_gpio_imatrix.sv
// rtl/boa_peri_gpio_imatrix.sv - GPIO input matrix: sync, glitch filter, routing, edge irq
module boa_peri_gpio_imatrix #(
  parameter logic [31:0] addr    = 32'h8000_0200,
  parameter int          pins    = 32,
  parameter int          num_ext = 8
) (
  input  logic               clk,
  input  logic               rst,
  boa_mem_bus.MEM            bus,
  input  logic [pins-1:0]    pin_in,
  output logic [num_ext-1:0] ext_in,
  output logic               irq
);

  logic [pins-1:0] s1, s2, filt, filt_nxt;
  logic [7:0]      cnt     [pins];
  logic [7:0]      cnt_nxt [pins];
  logic [7:0]      filt_len;
  logic [pins-1:0] rise_en, fall_en, status, set_v, clr_v;
  logic [15:0]     cfg_sel [num_ext];
  logic            cfg_inv [num_ext];
  logic            cfg_en  [num_ext];
  logic [31:0]     rdata_q, rd_val;
  logic [7:0]      offs;
  logic            hit, wr_full, v;

  assign hit        = bus.addr[29:6] == addr[31:8];
  assign offs       = {bus.addr[5:0], 2'b00};
  assign wr_full    = hit && (bus.we == 4'hF);
  assign bus.ready  = 1'b1;
  assign bus.rdata  = rdata_q;
  assign irq        = |status;

  // A level must disagree with filt for filt_len+1 consecutive samples.
  always_comb begin
    for (int i = 0; i < pins; i++) begin
      filt_nxt[i] = filt[i];
      cnt_nxt[i]  = 8'd0;
      if (s2[i] != filt[i]) begin
        if (cnt[i] == filt_len) filt_nxt[i] = s2[i];
        else                    cnt_nxt[i]  = cnt[i] + 8'd1;
      end
    end
  end

  assign set_v = (filt_nxt & ~filt & rise_en) | (~filt_nxt & filt & fall_en);
  assign clr_v = (wr_full && offs == 8'h0C) ? bus.wdata[pins-1:0] : '0;

  always_comb begin
    rd_val = '0;
    case (offs)
      8'h00: rd_val[pins-1:0] = filt;
      8'h04: rd_val[pins-1:0] = rise_en;
      8'h08: rd_val[pins-1:0] = fall_en;
      8'h0C: rd_val[pins-1:0] = status;
      8'h10: rd_val[7:0]      = filt_len;
      default: begin
        for (int n = 0; n < num_ext; n++)
          if (offs == 8'(128 + 4 * n))
            rd_val = {14'd0, cfg_en[n], cfg_inv[n], cfg_sel[n]};
      end
    endcase
  end

  // Out-of-range selects match no pin and therefore route 0.
  always_comb begin
    ext_in = '0;
    v      = 1'b0;
    for (int n = 0; n < num_ext; n++) begin
      v = 1'b0;
      for (int p = 0; p < pins; p++)
        if (cfg_sel[n] == 16'(p)) v = filt[p];
      ext_in[n] = cfg_en[n] & (v ^ cfg_inv[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      filt     <= '0;
      filt_len <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < pins; i++) cnt[i] <= 8'd0;
      for (int n = 0; n < num_ext; n++) begin
        cfg_sel[n] <= 16'd0;
        cfg_inv[n] <= 1'b0;
        cfg_en[n]  <= 1'b0;
      end
    end else begin
      s1     <= pin_in;
      s2     <= s1;
      filt   <= filt_nxt;
      for (int i = 0; i < pins; i++) cnt[i] <= cnt_nxt[i];
      status <= (status & ~clr_v) | set_v;
      if (hit) rdata_q <= rd_val;
      if (wr_full) begin
        case (offs)
          8'h04: rise_en  <= bus.wdata[pins-1:0];
          8'h08: fall_en  <= bus.wdata[pins-1:0];
          8'h10: filt_len <= bus.wdata[7:0];
          default: begin
            for (int n = 0; n < num_ext; n++)
              if (offs == 8'(128 + 4 * n)) begin
                cfg_sel[n] <= bus.wdata[15:0];
                cfg_inv[n] <= bus.wdata[16];
                cfg_en[n]  <= bus.wdata[17];
              end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boa_peri_gpio_imatrix.sv
// tb/tb_boa_peri_gpio_imatrix.sv - self-checking bench for boa_peri_gpio_imatrix
module tb_boa_peri_gpio_imatrix;
  localparam logic [31:0] BASE = 32'h8000_0200;
  localparam logic [29:0] IDLE = 30'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pin_in;
  logic [7:0]  ext_in;
  logic        irq;

  boa_mem_bus bus ();

  boa_peri_gpio_imatrix #(.addr(BASE), .pins(32), .num_ext(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pin_in(pin_in), .ext_in(ext_in), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] hist[$];
  logic [31:0] m_filt, m_rise, m_fall, m_status, m_rdata;
  logic [7:0]  m_flen;
  logic [15:0] m_sel[8];
  logic        m_inv[8];
  logic        m_en[8];
  logic [31:0] d;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 300; i++) hist.push_back(32'h0);
    m_filt = 0; m_rise = 0; m_fall = 0; m_status = 0; m_rdata = 0; m_flen = 0;
    for (int n = 0; n < 8; n++) begin
      m_sel[n] = 0; m_inv[n] = 0; m_en[n] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(logic [7:0] off);
    logic [31:0] r;
    r = 0;
    case (off)
      8'h00: r = m_filt;
      8'h04: r = m_rise;
      8'h08: r = m_fall;
      8'h0C: r = m_status;
      8'h10: r = {24'h0, m_flen};
      default:
        for (int n = 0; n < 8; n++)
          if (off == 8'(128 + 4 * n)) r = {14'h0, m_en[n], m_inv[n], m_sel[n]};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] m_ext();
    logic [7:0] e;
    e = 0;
    for (int n = 0; n < 8; n++)
      if (m_en[n] && m_sel[n] < 16'd32) e[n] = m_filt[m_sel[n][4:0]] ^ m_inv[n];
    return e;
  endfunction

  // One clock edge: advance the model from the pin history, then compare.
  task automatic step();
    logic [31:0] byte_a, nf, setv, clr, smp;
    logic [7:0]  off;
    logic        hit, full, differ;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hist.push_front(pin_in);
      void'(hist.pop_back());
      nf = m_filt;
      for (int i = 0; i < 32; i++) begin
        differ = 1'b1;
        for (int j = 0; j <= int'(m_flen); j++) begin
          smp = hist[2 + j];
          if (smp[i] == m_filt[i]) differ = 1'b0;
        end
        if (differ) nf[i] = ~m_filt[i];
      end
      byte_a = {bus.addr, 2'b00};
      hit    = byte_a[31:8] == BASE[31:8];
      off    = byte_a[7:0];
      full   = hit && bus.we == 4'hF;
      if (hit) m_rdata = m_read(off);
      setv = (nf & ~m_filt & m_rise) | (~nf & m_filt & m_fall);
      clr  = (full && off == 8'h0C) ? bus.wdata : 32'h0;
      m_status = (m_status & ~clr) | setv;
      if (full) begin
        case (off)
          8'h04: m_rise = bus.wdata;
          8'h08: m_fall = bus.wdata;
          8'h10: m_flen = bus.wdata[7:0];
          default:
            for (int n = 0; n < 8; n++)
              if (off == 8'(128 + 4 * n)) begin
                m_sel[n] = bus.wdata[15:0];
                m_inv[n] = bus.wdata[16];
                m_en[n]  = bus.wdata[17];
              end
        endcase
      end
      m_filt = nf;
    end
    #2;
    check("ext_in", 32'(ext_in), 32'(m_ext()));
    check("irq", 32'(irq), 32'(|m_status));
    check("rdata", bus.rdata, m_rdata);
  endtask

  task automatic wr(logic [7:0] off, logic [31:0] data, logic [3:0] we = 4'hF);
    bus.addr  = 30'((BASE + 32'(off)) >> 2);
    bus.we    = we;
    bus.wdata = data;
    step();
    bus.we    = 4'h0;
    bus.addr  = IDLE;
  endtask

  task automatic rd(logic [8:0] off, output logic [31:0] data);
    bus.addr = 30'((BASE + 32'(off)) >> 2);
    bus.we   = 4'h0;
    step();
    data     = bus.rdata;
    bus.addr = IDLE;
  endtask

  logic [31:0] pat_val [10] = '{32'h0000_0001, 32'h0000_0003, 32'h8000_0003, 32'h8000_0000,
                                32'h00FF_0000, 32'h00F0_0F00, 32'hFFFF_FFFF, 32'h0000_0000,
                                32'h1234_5678, 32'h0000_0000};
  int          pat_len [10] = '{1, 3, 2, 5, 1, 4, 6, 2, 3, 6};

  initial begin
    rst = 1'b1; pin_in = 0;
    bus.addr = IDLE; bus.we = 0; bus.wdata = 0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    foreach (pat_len[k]) begin end
    rd(9'h00, d); check("rst_input", d, 32'h0);
    rd(9'h04, d); check("rst_rise", d, 32'h0);
    rd(9'h08, d); check("rst_fall", d, 32'h0);
    rd(9'h0C, d); check("rst_status", d, 32'h0);
    rd(9'h10, d); check("rst_filt", d, 32'h0);
    rd(9'h80, d); check("rst_cfg0", d, 32'h0);
    check("rst_ext", 32'(ext_in), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // FILT=0 latency
    pin_in[3] = 1'b1;
    step(); step();
    rd(9'h00, d); check("input_n2_sample", d, 32'h0);
    rd(9'h00, d); check("input_n3", d, 32'h0000_0008);
    pin_in[3] = 1'b0;
    repeat (4) step();

    // FILT=3: short pulse rejected, 5-cycle pulse accepted
    wr(8'h10, 32'd3);
    wr(8'h04, 32'h20);
    pin_in[5] = 1'b1; repeat (3) step(); pin_in[5] = 1'b0;
    repeat (10) step();
    rd(9'h00, d); check("short_pulse_input", d, 32'h0);
    rd(9'h0C, d); check("short_pulse_status", d, 32'h0);
    pin_in[5] = 1'b1; repeat (4) step();
    rd(9'h00, d); check("pulse5_n4", d, 32'h0);
    pin_in[5] = 1'b0;
    rd(9'h00, d); check("pulse5_n5", d, 32'h0);
    rd(9'h00, d); check("pulse5_n6", d, 32'h20);
    rd(9'h0C, d); check("pulse5_status", d, 32'h20);
    check("pulse5_irq", 32'(irq), 32'h1);
    wr(8'h0C, 32'h20);
    check("pulse5_irq_clr", 32'(irq), 32'h0);
    wr(8'h04, 32'h0);
    repeat (10) step();

    // Rising-edge flag, W1C, and W1C colliding with set
    wr(8'h04, 32'h80);
    pin_in[7] = 1'b1; repeat (8) step();
    rd(9'h0C, d); check("rise7_status", d, 32'h80);
    check("rise7_irq", 32'(irq), 32'h1);
    wr(8'h0C, 32'h80);
    rd(9'h0C, d); check("rise7_cleared", d, 32'h0);
    check("rise7_irq_clr", 32'(irq), 32'h0);
    pin_in[7] = 1'b0; repeat (10) step();
    pin_in[7] = 1'b1; repeat (5) step();
    wr(8'h0C, 32'h80);
    rd(9'h0C, d); check("w1c_vs_set", d, 32'h80);
    wr(8'h0C, 32'h80);
    pin_in[7] = 1'b0; repeat (10) step();

    // Routing, invert, shared pin, out-of-range select
    wr(8'h88, 32'h0003_0004);
    wr(8'h80, 32'h0002_0004);
    wr(8'h84, 32'h0002_0004);
    pin_in[4] = 1'b1; repeat (8) step();
    check("route_pin4", 32'(ext_in), 32'h03);
    wr(8'h88, 32'h0002_0028);
    check("route_oor", 32'(ext_in), 32'h03);
    rd(9'h88, d); check("cfg2_read", d, 32'h0002_0028);
    wr(8'h08, 32'h10);
    pin_in[4] = 1'b0; repeat (8) step();
    wr(8'h08, 32'h0);
    rd(9'h0C, d); check("fall_kept_pending", d, 32'h10);
    wr(8'h0C, 32'h10);

    // Partial write, out-of-window read, unmapped reads
    wr(8'h04, 32'hFFFF_FFFF, 4'h3);
    rd(9'h04, d); check("partial_we", d, 32'h80);
    rd(9'h100, d); check("out_of_window", d, 32'h80);
    rd(9'h0A0, d); check("cfg8_unmapped", d, 32'h0);
    rd(9'h10, d); check("filt_read", d, 32'h3);

    // Directed pin patterns with FILT=1 and all edges enabled
    wr(8'h10, 32'd1);
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h08, 32'h0000_FFFF);
    wr(8'h98, 32'h0002_001F);
    for (int k = 0; k < 10; k++) begin
      pin_in = pat_val[k];
      repeat (pat_len[k]) step();
      if (k == 5) wr(8'h0C, 32'hFFFF_FFFF);
      rd(9'h00, d);
    end
    rd(9'h0C, d);

    // Reset mid-filter
    pin_in = 32'hAAAA_5555;
    step(); step();
    rst = 1'b1; step(); step();
    rst = 1'b0;
    rd(9'h04, d); check("rst2_rise", d, 32'h0);
    check("rst2_irq", 32'(irq), 32'h0);
    repeat (6) step();
    rd(9'h00, d); check("rst2_input", d, 32'hAAAA_5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
